// File: rtl/shift_pipe_n.sv
// shift_pipe_n: pipelined SLL/SRL/SRA/ROL shifter, one stage per shamt bit.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_shamt/in_op;
//   out_valid/out_ready/out_data; out_sticky/out_zero when SHIFT_FLAGS_EN.
// in_op: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Define SHIFT_FLAGS_EN for the flags.
module shift_pipe_n #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef SHIFT_FLAGS_EN
   output logic             out_sticky,
   output logic             out_zero,
`endif
   output logic [WIDTH-1:0] out_data
);

   localparam int NM = SHW - 1;
   localparam logic [WIDTH-1:0] ONES = '1;

   logic             adv;
   logic [SHW-1:0]   vld_q;
   logic [WIDTH-1:0] dat_q [SHW];
   logic [WIDTH-1:0] dat_d [SHW];

   // Control carried to the following stage; the last stage needs none.
   logic [SHW-1:0]   rem_q [NM];
   logic [1:0]       op_q  [NM];
   logic [NM-1:0]    sgn_q;

   logic [WIDTH-1:0] src_dat [SHW];
   logic [SHW-1:0]   src_rem [SHW];
   logic [1:0]       src_op  [SHW];
   logic [SHW-1:0]   src_sgn;
   logic [SHW-1:0]   src_vld;

`ifdef SHIFT_FLAGS_EN
   logic [SHW-1:0]   disc;
   logic [SHW-1:0]   stk_q;
   logic [SHW-1:0]   stk_d;
   logic             zero_q;
`endif

   assign adv       = !vld_q[SHW-1] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[SHW-1];
   assign out_data  = dat_q[SHW-1];
   assign src_vld   = {vld_q[SHW-2:0], in_valid};

`ifdef SHIFT_FLAGS_EN
   assign out_sticky = stk_q[SHW-1];
   assign out_zero   = zero_q;
   assign stk_d      = {stk_q[SHW-2:0], 1'b0} | disc;
`endif

   always_comb begin
      src_dat[0] = in_data;
      src_rem[0] = in_shamt;
      src_op[0]  = in_op;
      src_sgn[0] = in_data[WIDTH-1];
      for (int k = 1; k < SHW; k++) begin
         src_dat[k] = dat_q[k-1];
         src_rem[k] = rem_q[k-1];
         src_op[k]  = op_q[k-1];
         src_sgn[k] = sgn_q[k-1];
      end
`ifdef SHIFT_FLAGS_EN
      disc = '0;
`endif
      for (int k = 0; k < SHW; k++) begin
         dat_d[k] = src_dat[k];
         if (src_rem[k][0]) begin
            unique case (src_op[k])
               2'b00: begin
                  dat_d[k] = src_dat[k] << (1 << k);
`ifdef SHIFT_FLAGS_EN
                  disc[k] = |(src_dat[k] >> (WIDTH - (1 << k)));
`endif
               end
               2'b01: begin
                  dat_d[k] = src_dat[k] >> (1 << k);
`ifdef SHIFT_FLAGS_EN
                  disc[k] = |(src_dat[k] & ~(ONES << (1 << k)));
`endif
               end
               2'b10: begin
                  // Fill from the operand's original sign, not this
                  // stage's MSB, so every stage agrees on the fill.
                  dat_d[k] = (src_dat[k] >> (1 << k))
                           | (src_sgn[k] ? ~(ONES >> (1 << k)) : '0);
`ifdef SHIFT_FLAGS_EN
                  disc[k] = |(src_dat[k] & ~(ONES << (1 << k)));
`endif
               end
               2'b11: begin
                  dat_d[k] = (src_dat[k] << (1 << k))
                           | (src_dat[k] >> (WIDTH - (1 << k)));
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         sgn_q <= '0;
         for (int k = 0; k < SHW; k++) begin
            dat_q[k] <= '0;
         end
         for (int k = 0; k < NM; k++) begin
            rem_q[k] <= '0;
            op_q[k]  <= '0;
         end
`ifdef SHIFT_FLAGS_EN
         stk_q  <= '0;
         zero_q <= 1'b0;
`endif
      end else if (adv) begin
         vld_q <= src_vld;
         // Payload only moves with a valid beat; bubbles leave it alone.
         for (int k = 0; k < SHW; k++) begin
            if (src_vld[k]) begin
               dat_q[k] <= dat_d[k];
`ifdef SHIFT_FLAGS_EN
               stk_q[k] <= stk_d[k];
`endif
            end
         end
         for (int k = 0; k < NM; k++) begin
            if (src_vld[k]) begin
               rem_q[k] <= src_rem[k] >> 1;
               op_q[k]  <= src_op[k];
               sgn_q[k] <= src_sgn[k];
            end
         end
`ifdef SHIFT_FLAGS_EN
         if (src_vld[SHW-1]) begin
            zero_q <= (dat_d[SHW-1] == '0);
         end
`endif
      end
   end

endmodule
